debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised multi-channel successor to the single-input debouncer: filters CHANNELS independent noisy inputs (buttons, switches, external strobes) against a shared run-time stability window and reports, per channel, the clean level plus single-cycle rise/fall event pulses. It sits between the board I/O pins and the CPU's control/MMIO logic, so software and FSMs never see bounce.

## Interface
Parameters:
- CHANNELS, 4, number of independent input channels (1..32)
- CNT_W, 24, width of the stability counter and of `width`
- INIT, {CHANNELS{1'b0}}, per-channel reset level of `clean` (and of the synchroniser flops when compiled in)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- width  input  CNT_W  required number of consecutive stable samples; 0 treated as 1; may change at any time
- en  input  CHANNELS  per-channel enable; 0 freezes that channel
- dirty  input  CHANNELS  raw asynchronous inputs
- clean  output  CHANNELS  debounced level
- rise  output  CHANNELS  one-cycle pulse when `clean[i]` goes 0->1
- fall  output  CHANNELS  one-cycle pulse when `clean[i]` goes 1->0
- any_evt  output  1  registered OR of all `rise|fall` bits

## Operation
- Per channel i: sample `s[i]` (raw `dirty[i]`, or synchroniser output, see Configuration), counter `cnt[i]` (CNT_W bits), state `clean[i]`.
- Effective window W = (width == 0) ? 1 : width.
- On each edge with `en[i]`=1:
  - `s[i]` == `clean[i]`: `cnt[i]` <= 0.
  - `s[i]` != `clean[i]` and `cnt[i]` >= W-1: `clean[i]` <= `s[i]`, `cnt[i]` <= 0, pulse `rise[i]` or `fall[i]`.
  - otherwise: `cnt[i]` <= `cnt[i]`+1.
- `>=` compare: lowering `width` mid-count commits on the next differing sample, never stalls; raising it extends the wait. Counter never wraps (max reached value W-1 ≤ 2^CNT_W-2).
- Any sample equal to `clean[i]` during a count restarts the count from 0 (glitch rejection).
- `en[i]`=0: `cnt[i]` <= 0, `clean[i]` held, no pulses; synchroniser keeps sampling. Re-enable restarts a full window.
- Channels fully independent; simultaneous commits on several channels all pulse in the same cycle.

## Timing
- Reset (rst=0, asynchronous): `clean` = INIT, all `cnt` = 0, `rise`=`fall`=0, `any_evt`=0, synchroniser flops = INIT. Reset mid-count discards progress; first count starts at the first edge after rst deasserts.
- Latency without synchroniser: new level on `dirty[i]` sampled at edge k; if stable, `clean[i]` changes at edge k+W-1 (W consecutive samples k..k+W-1).
- With synchroniser: +2 edges.
- `rise`/`fall` registered concurrently with the `clean` change: high exactly the one cycle `clean` shows the new value first.
- `any_evt` one cycle after the corresponding `rise`/`fall`.

## Configuration
- DEBOUNCE_MULTI_SYNC_EN defined: each `dirty[i]` passes through a 2-flop synchroniser (reset to INIT[i]) before the counter; latency +2 cycles.
- Not defined: `dirty` fed directly to the compare logic (inputs must already be synchronous to clk); no extra flops.

## Test plan
- Reset/default: CHANNELS=4, INIT=4'b0101, hold rst=0 for 10 cycles then release -> `clean`=4'b0101, `rise`/`fall`/`any_evt`=0, stays so with `dirty`=4'b0101.
- Basic press: width=1000, 8 ns clock, `dirty[0]` 0->1 held 12 us -> `clean[0]` rises exactly 999 edges (+2 with sync) after first sampling edge; `rise[0]` high one cycle; `any_evt` one cycle later.
- Bounce rejection: `dirty[1]` toggles every 500 cycles for 6000 cycles with width=1000 -> `clean[1]` never changes, no pulses; then held 1 -> commits after 1000 samples.
- Width edge cases: width=0 and width=1 -> `clean` follows the sample on the next edge; lower width 1000->10 while `cnt`=500 -> commit on next differing sample.
- Enable/simultaneity: all four channels change on same edge, `en`=4'b1011 -> channels 0,1,3 pulse same cycle, channel 2 held; re-enable -> channel 2 commits a full W later.
- Reset mid-count: assert rst at `cnt`=700 -> outputs return to INIT immediately; after release, full 1000-sample window required.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel stability-window debouncer with rise/fall pulses; optional DEBOUNCE_MULTI_SYNC_EN adds 2-flop input synchronisers
module debounce_multi #(
   parameter int CHANNELS = 4,
   parameter int CNT_W = 24,
   parameter logic [CHANNELS-1:0] INIT = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CNT_W-1:0]    width,
   input  logic [CHANNELS-1:0] en,
   input  logic [CHANNELS-1:0] dirty,
   output logic [CHANNELS-1:0] clean,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_evt
);
   logic [CHANNELS-1:0] s, hit;
   logic [CNT_W-1:0] cnt [CHANNELS];
   logic [CNT_W-1:0] wm1;
`ifdef DEBOUNCE_MULTI_SYNC_EN
   logic [CHANNELS-1:0] meta;
   // two-flop synchroniser; keeps sampling even while a channel is disabled
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         meta <= INIT;
         s <= INIT;
      end else begin
         meta <= dirty;
         s <= meta;
      end
`else
   assign s = dirty;
`endif
   assign wm1 = (width == '0) ? '0 : width - CNT_W'(1);
   // commit when an enabled channel has differed for a full window; >= lets a lowered width commit at once
   always_comb begin
      hit = '0;
      for (int i = 0; i < CHANNELS; i++)
         hit[i] = en[i] && (s[i] != clean[i]) && (cnt[i] >= wm1);
   end
   // level, pulse and counter state; any sample equal to clean or a disable restarts the count
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         clean <= INIT;
         rise <= '0;
         fall <= '0;
         any_evt <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      end else begin
         clean <= (clean & ~hit) | (s & hit);
         rise <= hit & s;
         fall <= hit & ~s;
         any_evt <= |(rise | fall);
         for (int i = 0; i < CHANNELS; i++)
            cnt[i] <= (en[i] && (s[i] != clean[i]) && !hit[i]) ? cnt[i] + CNT_W'(1) : '0;
      end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: randomized and directed checks of debounce_multi against a run-length reference model
module tb_debounce_multi;
   localparam int CH = 4;
   localparam int CW = 12;
   localparam logic [CH-1:0] INIT = 4'b0101;
`ifdef DEBOUNCE_MULTI_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   logic clk = 0, rst = 0;
   logic [CW-1:0] width = 1000;
   logic [CH-1:0] en = '1, dirty = INIT;
   logic [CH-1:0] clean, rise, fall;
   logic any_evt;
   int n_chk = 0, n_err = 0;
   logic [CH-1:0] m_clean, m_rise, m_fall, p1, p2;
   logic m_any;
   int run [CH];

   debounce_multi #(.CHANNELS(CH), .CNT_W(CW), .INIT(INIT)) dut (
      .clk(clk), .rst(rst), .width(width), .en(en), .dirty(dirty),
      .clean(clean), .rise(rise), .fall(fall), .any_evt(any_evt));

   always #4 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_clean = INIT; m_rise = '0; m_fall = '0; m_any = 0; p1 = INIT; p2 = INIT;
      for (int i = 0; i < CH; i++) run[i] = 0;
   endtask

   // one clock edge of the reference: a level commits after W consecutive enabled differing samples
   task automatic step();
      int w;
      logic [CH-1:0] smp;
      if (!rst) begin model_reset(); return; end
      w = (width == 0) ? 1 : int'(width);
      smp = (SYNC != 0) ? p2 : dirty;
      m_any = |(m_rise | m_fall);
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < CH; i++) begin
         if (!en[i] || smp[i] == m_clean[i]) run[i] = 0;
         else begin
            run[i]++;
            if (run[i] >= w) begin
               m_clean[i] = smp[i]; run[i] = 0;
               if (smp[i]) m_rise[i] = 1; else m_fall[i] = 1;
            end
         end
      end
      p2 = p1; p1 = dirty;
   endtask

   task automatic cycle();
      @(posedge clk); step();
      @(negedge clk);
      chk("outs", 32'({any_evt, fall, rise, clean}), 32'({m_any, m_fall, m_rise, m_clean}));
   endtask

   // edges from the first sampling edge (index 0) until clean[ch] changes; -1 if it never does
   task automatic wait_change(input int ch, input int lim, output int n);
      logic old;
      n = -1;
      for (int k = 0; k < lim; k++) begin
         old = clean[ch];
         cycle();
         if (clean[ch] != old) begin n = k; break; end
      end
   endtask

   initial begin
      int n, bad;
      logic [CH-1:0] old;
      model_reset();
      @(negedge clk);
      repeat (10) cycle();
      chk("rst_clean", 32'(clean), 32'(INIT));
      chk("rst_pulses", 32'({any_evt, fall, rise}), 0);
      rst = 1;
      repeat (20) cycle();
      chk("idle_clean", 32'(clean), 32'(INIT));
      chk("idle_pulses", 32'({any_evt, fall, rise}), 0);
      // basic press on channel 0 (released first since INIT[0]=1)
      dirty[0] = 0;
      wait_change(0, 1500, n);
      chk("release_lat", n, 999 + SYNC);
      dirty[0] = 1;
      wait_change(0, 1500, n);
      chk("press_lat", n, 999 + SYNC);
      chk("press_rise", 32'(rise), 1);
      cycle();
      chk("press_any", 32'({any_evt, rise}), 32'(5'b10000));
      repeat (400) cycle();
      // bounce rejection on channel 1
      bad = 0;
      for (int k = 0; k < 6000; k++) begin
         dirty[1] = ((k / 500) % 2) == 0;
         cycle();
         if (rise[1] | fall[1]) bad++;
      end
      chk("bounce_pulses", bad, 0);
      chk("bounce_level", 32'(clean[1]), 0);
      dirty[1] = 1;
      wait_change(1, 1200, n);
      chk("bounce_commit", n, 999 + SYNC);
      // width 0 and 1 follow next edge
      width = 0; dirty[2] = ~clean[2];
      wait_change(2, 10, n);
      chk("width0_lat", n, SYNC);
      width = 1; dirty[2] = ~clean[2];
      wait_change(2, 10, n);
      chk("width1_lat", n, SYNC);
      // lowering the width mid-count commits on the next differing sample
      width = 1000; dirty[2] = ~clean[2];
      repeat (500) cycle();
      width = 10;
      wait_change(2, 10, n);
      chk("width_lower", n, 0);
      // simultaneous commits with channel 2 disabled
      width = 20; en = 4'b1011; old = clean; dirty = ~old;
      wait_change(0, 40, n);
      chk("simul_lat", n, 19 + SYNC);
      chk("simul_clean", 32'(clean ^ old), 32'(4'b1011));
      chk("simul_pulse", 32'(rise | fall), 32'(4'b1011));
      repeat (5) cycle();
      chk("dis_held", 32'(clean[2]), 32'(old[2]));
      en = '1;
      wait_change(2, 40, n);
      chk("reen_lat", n, 19);
      // reset mid-count discards progress
      width = 1000; dirty = clean ^ 4'b1000;
      repeat (700) cycle();
      rst = 0; #1; model_reset();
      chk("amid_rst", 32'({any_evt, fall, rise, clean}), 32'(INIT));
      @(negedge clk);
      repeat (3) cycle();
      rst = 1; dirty = INIT ^ 4'b1000;
      wait_change(3, 1200, n);
      chk("post_rst_lat", n, 999 + SYNC);
      // random traffic
      for (int k = 0; k < 3000; k++) begin
         if (k % 200 == 0) width = CW'($urandom_range(0, 8));
         if (k % 150 == 0) en = ($urandom_range(0, 2) == 0) ? CH'($urandom) : '1;
         if ($urandom_range(0, 5) == 0) dirty[$urandom_range(0, CH - 1)] ^= 1'b1;
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
